// File: rtl/mem_io_pkg.sv
// Shared address-map constants, timer register offsets and ctrl bit positions.
package mem_io_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OFF_W  = 2;

    // ADDR[15:12] region codes
    localparam logic [REG_W-1:0] REG_RAM = 4'h0;
    localparam logic [REG_W-1:0] REG_LED = 4'h1;
    localparam logic [REG_W-1:0] REG_SW  = 4'h3;
    localparam logic [REG_W-1:0] REG_TMR = 4'h4;

    // Timer register offsets, ADDR[1:0]
    localparam logic [OFF_W-1:0] TMR_CTRL  = 2'd0;
    localparam logic [OFF_W-1:0] TMR_LOAD  = 2'd1;
    localparam logic [OFF_W-1:0] TMR_COUNT = 2'd2;
    localparam logic [OFF_W-1:0] TMR_STAT  = 2'd3;

    // Ctrl register bit indices
    localparam int unsigned CTRL_RUN  = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IE   = 2;

    typedef enum logic {
        TMR_IDLE     = 1'b0,
        TMR_COUNTING = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/io_timer.sv
// Countdown timer: ctrl/load/count/status registers, run FSM and interrupt.
module io_timer
    import mem_io_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              i_we,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic              o_irq_c
);

    tmr_state_e        r_state, w_state_nxt;
    logic              r_auto, w_auto_nxt;
    logic              r_ie, w_ie_nxt;
    logic              r_to, w_to_nxt;
    logic [DATA_W-1:0] r_load, w_load_nxt;
    logic [DATA_W-1:0] r_count, w_count_nxt;

    // State and register update
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= TMR_IDLE;
            r_auto  <= 1'b0;
            r_ie    <= 1'b0;
            r_to    <= 1'b0;
            r_load  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_auto  <= w_auto_nxt;
            r_ie    <= w_ie_nxt;
            r_to    <= w_to_nxt;
            r_load  <= w_load_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next state: status clear first so a timeout on the same edge wins,
    // then countdown, then ctrl write which has the last word on RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_auto_nxt  = r_auto;
        w_ie_nxt    = r_ie;
        w_to_nxt    = r_to;
        w_load_nxt  = r_load;
        w_count_nxt = r_count;

        if (i_we && i_offset == TMR_STAT) w_to_nxt = 1'b0;
        if (i_we && i_offset == TMR_LOAD) w_load_nxt = i_wdata;

        case (r_state)
            TMR_IDLE: ;
            TMR_COUNTING: begin
                if (r_count != '0) begin
                    w_count_nxt = r_count - DATA_W'(1);
                end else begin
                    w_to_nxt = 1'b1;
                    if (r_auto) w_count_nxt = r_load;
                    else        w_state_nxt = TMR_IDLE;
                end
            end
            default: w_state_nxt = TMR_IDLE;
        endcase

        if (i_we && i_offset == TMR_CTRL) begin
            w_auto_nxt = i_wdata[CTRL_AUTO];
            w_ie_nxt   = i_wdata[CTRL_IE];
            if (i_wdata[CTRL_RUN]) begin
                w_state_nxt = TMR_COUNTING;
                if (r_state == TMR_IDLE) w_count_nxt = r_load;
            end else begin
                w_state_nxt = TMR_IDLE;
                w_count_nxt = r_count;
            end
        end
    end

    // Register read mux, zero-extended
    always_comb begin
        o_rdata_c = '0;
        case (i_offset)
            TMR_CTRL:  o_rdata_c = DATA_W'({r_ie, r_auto, r_state == TMR_COUNTING});
            TMR_LOAD:  o_rdata_c = r_load;
            TMR_COUNT: o_rdata_c = r_count;
            TMR_STAT:  o_rdata_c = DATA_W'(r_to);
            default:   o_rdata_c = '0;
        endcase
    end

    assign o_irq_c = r_to & r_ie;

endmodule

// File: rtl/mem_io_responder.sv
// Processor bus responder: RAM, LED register, synchronized switches, timer.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_AW = 8,
    parameter int unsigned IO_W   = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DOUT,
    input  logic              W,
    output logic [DATA_W-1:0] DIN,
    input  logic [IO_W-1:0]   SW,
    output logic [IO_W-1:0]   LEDR,
    output logic              IRQ
);

    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

    logic [DATA_W-1:0] r_ram [RAM_DEPTH];
    logic [IO_W-1:0]   r_sw_meta, r_sw_sync;
    logic [REG_W-1:0]  w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [DATA_W-1:0] w_rdata, w_tmr_rdata;
    logic              w_tmr_we, w_irq;
    logic              w_unused_addr;

    assign w_region      = ADDR[15:12];
    assign w_ram_idx     = ADDR[RAM_AW-1:0];
    assign w_tmr_we      = W && (w_region == REG_TMR);
    assign w_unused_addr = ^ADDR[11:RAM_AW];

    io_timer u_timer (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .i_we      (w_tmr_we),
        .i_offset  (ADDR[OFF_W-1:0]),
        .i_wdata   (DOUT),
        .o_rdata_c (w_tmr_rdata),
        .o_irq_c   (w_irq)
    );

    assign IRQ = w_irq;

    // RAM write port; contents deliberately not reset
    always_ff @(posedge Clock) begin
        if (W && w_region == REG_RAM) r_ram[w_ram_idx] <= DOUT;
    end

    // Read mux; RAM read sees pre-write contents, giving read-first behaviour
    always_comb begin
        w_rdata = '0;
        case (w_region)
            REG_RAM: w_rdata = r_ram[w_ram_idx];
            REG_LED: w_rdata = DATA_W'(LEDR);
            REG_SW:  w_rdata = DATA_W'(r_sw_sync);
            REG_TMR: w_rdata = w_tmr_rdata;
            default: w_rdata = '0;
        endcase
    end

    // Read data register, LED register and switch synchronizer
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            DIN       <= '0;
            LEDR      <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            DIN       <= w_rdata;
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (W && w_region == REG_LED) LEDR <= DOUT[IO_W-1:0];
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

    logic        Clock;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic        IRQ;

    int n_vec = 0;
    int n_err = 0;

    mem_io_responder #(.RAM_AW(8), .IO_W(10)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .ADDR   (ADDR),
        .DOUT   (DOUT),
        .W      (W),
        .DIN    (DIN),
        .SW     (SW),
        .LEDR   (LEDR),
        .IRQ    (IRQ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then settle 1ns
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; DOUT = d; W = 1'b1;
        step();
        W = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        ADDR = a; W = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Resetn = 1'b0; ADDR = '0; DOUT = '0; W = 1'b0; SW = '0;
        #3;
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL reset_din: got %h want 0000", DIN); end
        n_vec++; if (LEDR !== 10'h000) begin n_err++; $display("FAIL reset_ledr: got %h want 000", LEDR); end
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        @(negedge Clock);
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_ram();
        wr(16'h0005, 16'h1234);
        rd(16'h0005);
        n_vec++; if (DIN !== 16'h1234) begin n_err++; $display("FAIL ram_read: got %h want 1234", DIN); end
        rd(16'h0105);
        n_vec++; if (DIN !== 16'h1234) begin n_err++; $display("FAIL ram_alias: got %h want 1234", DIN); end
        wr(16'h0007, 16'hAAAA);
        wr(16'h0007, 16'h5555);
        n_vec++; if (DIN !== 16'hAAAA) begin n_err++; $display("FAIL ram_read_first: got %h want aaaa", DIN); end
        rd(16'h0007);
        n_vec++; if (DIN !== 16'h5555) begin n_err++; $display("FAIL ram_after_write: got %h want 5555", DIN); end
    endtask

    task automatic test_led_sw();
        wr(16'h1000, 16'hFFFF);
        n_vec++; if (LEDR !== 10'h3FF) begin n_err++; $display("FAIL led_reg: got %h want 3ff", LEDR); end
        rd(16'h1000);
        n_vec++; if (DIN !== 16'h03FF) begin n_err++; $display("FAIL led_read: got %h want 03ff", DIN); end
        ADDR = 16'h3000; SW = 10'h2A5;
        step();
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL sw_edge1: got %h want 0000", DIN); end
        step();
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL sw_edge2: got %h want 0000", DIN); end
        step();
        n_vec++; if (DIN !== 16'h02A5) begin n_err++; $display("FAIL sw_edge3: got %h want 02a5", DIN); end
    endtask

    task automatic test_unmapped();
        wr(16'h7000, 16'hBEEF);
        wr(16'h3000, 16'hBEEF);
        n_vec++; if (LEDR !== 10'h3FF) begin n_err++; $display("FAIL unmapped_led: got %h want 3ff", LEDR); end
        rd(16'h7000);
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", DIN); end
        rd(16'h3000);
        n_vec++; if (DIN !== 16'h02A5) begin n_err++; $display("FAIL sw_readonly: got %h want 02a5", DIN); end
        rd(16'h0005);
        n_vec++; if (DIN !== 16'h1234) begin n_err++; $display("FAIL ram_untouched: got %h want 1234", DIN); end
    endtask

    task automatic test_oneshot();
        wr(16'h4001, 16'd5);
        wr(16'h4000, 16'h0005);
        ADDR = 16'h4002;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL oneshot_early_irq%0d: got %b want 0", i, IRQ); end
            if (i == 1) begin
                n_vec++; if (DIN !== 16'd5) begin n_err++; $display("FAIL oneshot_count_start: got %h want 0005", DIN); end
            end
        end
        step();
        n_vec++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL oneshot_irq: got %b want 1", IRQ); end
        rd(16'h4000);
        n_vec++; if (DIN !== 16'h0004) begin n_err++; $display("FAIL oneshot_ctrl: got %h want 0004", DIN); end
        rd(16'h4002);
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL oneshot_count: got %h want 0000", DIN); end
        rd(16'h4003);
        n_vec++; if (DIN !== 16'h0001) begin n_err++; $display("FAIL oneshot_status: got %h want 0001", DIN); end
        wr(16'h4003, 16'h0000);
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL status_clear_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_auto_reload();
        wr(16'h4001, 16'd2);
        wr(16'h4000, 16'h0003);
        ADDR = 16'h4003;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL auto_pre_to%0d: got %h want 0000", i, DIN); end
        end
        wr(16'h4003, 16'h0000);
        n_vec++; if (DIN !== 16'h0001) begin n_err++; $display("FAIL auto_first_to: got %h want 0001", DIN); end
        step();
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL auto_cleared: got %h want 0000", DIN); end
        wr(16'h4003, 16'h0000);
        step();
        n_vec++; if (DIN !== 16'h0001) begin n_err++; $display("FAIL auto_set_wins: got %h want 0001", DIN); end
        wr(16'h4000, 16'h0002);
        rd(16'h4002);
        n_vec++; if (DIN !== 16'h0001) begin n_err++; $display("FAIL stop_count: got %h want 0001", DIN); end
        rd(16'h4002);
        n_vec++; if (DIN !== 16'h0001) begin n_err++; $display("FAIL stop_hold: got %h want 0001", DIN); end
        rd(16'h4000);
        n_vec++; if (DIN !== 16'h0002) begin n_err++; $display("FAIL stop_ctrl: got %h want 0002", DIN); end
        wr(16'h4003, 16'h0000);
    endtask

    task automatic test_reset_mid_count();
        wr(16'h4001, 16'd100);
        wr(16'h4000, 16'h0005);
        ADDR = 16'h4002;
        step();
        step();
        n_vec++; if (DIN !== 16'd99) begin n_err++; $display("FAIL mid_count: got %h want 0063", DIN); end
        #2;
        Resetn = 1'b0;
        #1;
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL async_rst_din: got %h want 0000", DIN); end
        n_vec++; if (LEDR !== 10'h000) begin n_err++; $display("FAIL async_rst_ledr: got %h want 000", LEDR); end
        n_vec++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL async_rst_irq: got %b want 0", IRQ); end
        @(negedge Clock);
        Resetn = 1'b1;
        rd(16'h4002);
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL rst_count: got %h want 0000", DIN); end
        step();
        step();
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL rst_idle: got %h want 0000", DIN); end
        rd(16'h4000);
        n_vec++; if (DIN !== 16'h0000) begin n_err++; $display("FAIL rst_ctrl: got %h want 0000", DIN); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_sw();
        test_unmapped();
        test_oneshot();
        test_auto_reload();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
